// File: rtl/sparrow_pkg.sv
// sparrow_pkg: shared types and constants for the sparrow core front end.
package sparrow_pkg;
    typedef enum logic {FETCH_BOOT, FETCH_RUN} fetch_state_e;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/sparrow_fetch_fifo.sv
// sparrow_fetch_fifo: synchronous FIFO of fetched instructions with flush.
module sparrow_fetch_fifo
    import sparrow_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = r_count == '0;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty;
    // a full FIFO may still accept a push when the head leaves in the same cycle
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) r_rd <= inc(r_rd);
            if (w_push) r_wr <= inc(r_wr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/sparrow_fetch.sv
// sparrow_fetch: instruction fetch stage; sequential word fetches, buffered
// delivery to decode, and wrong-path squashing on redirects.
module sparrow_fetch
    import sparrow_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  r_state;
    logic [31:0]   r_fetch_pc, r_resp_pc;
    logic [CW-1:0] r_outstanding, r_discard, w_count;
    logic [CW:0]   w_credit;
    logic [31:0]   w_target;
    logic          w_run, w_gnt, w_live, w_push, w_pop, w_empty, w_full;
    fetch_entry_t  w_head;

    assign w_run         = r_state == FETCH_RUN;
    assign w_target      = {redirect_pc_i[31:2], 2'b00};
    // r_outstanding counts every in-flight response, wrong-path ones included,
    // so discard can never exceed it and both counters stay within CW bits
    assign w_credit      = {1'b0, r_outstanding} + {1'b0, w_count};
    assign imem_req_o    = w_run && !redirect_i && (w_credit < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr_o   = r_fetch_pc;
    assign w_gnt         = imem_req_o && imem_gnt_i;
    assign w_live        = imem_rvalid_i && r_discard == '0;
    assign w_push        = w_live && !redirect_i;
    assign instr_valid_o = !w_empty && !redirect_i;
    assign w_pop         = instr_valid_o && instr_ready_i;
    assign instr_o       = w_head.instr;
    assign instr_pc_o    = w_head.pc;

    sparrow_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_push),
        .i_data  ('{instr: imem_rdata_i, pc: r_resp_pc}),
        .i_pop   (w_pop),
        .i_flush (redirect_i && w_run),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= FETCH_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state <= FETCH_RUN;
            if (redirect_i) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                if (w_run) begin
                    r_outstanding <= r_outstanding - CW'(imem_rvalid_i);
                    r_discard     <= r_outstanding - CW'(imem_rvalid_i);
                end
            end else begin
                if (w_gnt) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
                if (imem_rvalid_i && !w_live) r_discard <= r_discard - 1'b1;
                r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(imem_rvalid_i);
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_push && w_full));
endmodule

// File: tb/tb_sparrow_fetch.sv
// tb_sparrow_fetch: directed and random stimulus against a queue-based model
// of in-flight fetches and the decode buffer.
module tb_sparrow_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk_i = 1'b0, rst_ni;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        redirect_i, instr_valid_o, instr_ready_i;
    logic [31:0] redirect_pc_i, instr_o, instr_pc_o;

    sparrow_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic [31:0] addr; bit doomed;} fl_t;
    typedef struct {logic [31:0] instr; logic [31:0] pc;} be_t;

    fl_t         inflight[$];
    be_t         buffer[$];
    logic [31:0] m_fetch;
    bit          m_run;
    int          n_checks = 0, n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5a5a_0000) * 32'h9e37_79b1 + 32'h13;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        inflight.delete();
        buffer.delete();
        m_fetch = RPC;
        m_run   = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, RPC);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
    endtask

    // one cycle: entered and left at a falling edge
    task automatic step(input bit g, input bit rv, input bit rd, input logic [31:0] tgt, input bit rdy);
        bit  exp_req, exp_valid, got_rv;
        fl_t e;
        imem_gnt_i    = g;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        instr_ready_i = rdy;
        got_rv        = rv && inflight.size() > 0;
        imem_rvalid_i = got_rv;
        imem_rdata_i  = got_rv ? mem_word(inflight[0].addr) : 32'($urandom);
        #1;
        exp_req   = m_run && !rd && (inflight.size() + buffer.size() < DEPTH);
        exp_valid = buffer.size() > 0 && !rd;
        check("req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) check("addr", imem_addr_o, m_fetch);
        check("valid", 32'(instr_valid_o), 32'(exp_valid));
        check("instr", instr_o, buffer.size() > 0 ? buffer[0].instr : 32'd0);
        check("instr_pc", instr_pc_o, buffer.size() > 0 ? buffer[0].pc : 32'd0);
        @(posedge clk_i);
        if (got_rv) e = inflight.pop_front();
        if (rd) begin
            m_fetch = {tgt[31:2], 2'b00};
            if (m_run) begin
                foreach (inflight[i]) inflight[i].doomed = 1;
                buffer.delete();
            end
        end else begin
            if (exp_valid && rdy) void'(buffer.pop_front());
            if (got_rv && !e.doomed) buffer.push_back('{instr: mem_word(e.addr), pc: e.addr});
            if (exp_req && g) begin
                inflight.push_back('{addr: m_fetch, doomed: 1'b0});
                m_fetch += 32'd4;
            end
        end
        m_run = 1;
        @(negedge clk_i);
    endtask

    task automatic random_steps(input int n);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = ($urandom_range(0, 3) == 0) ? 32'hffff_fff0 | 32'($urandom_range(0, 15)) : 32'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 11) == 0, t, $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        rst_ni = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_reset_outputs();
        rst_ni = 1;
        // boot with single-cycle memory
        repeat (8) step(1, 1, 0, 32'h0, 1);
        // backpressure then drain
        repeat (6) step(1, 1, 0, 32'h0, 0);
        repeat (6) step(1, 1, 0, 32'h0, 1);
        // redirect with two requests outstanding
        repeat (3) step(1, 0, 0, 32'h0, 1);
        step(1, 0, 1, 32'h0000_0100, 1);
        repeat (8) step(1, 1, 0, 32'h0, 1);
        // redirect coinciding with a response while decode is ready
        step(1, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        step(1, 1, 1, 32'h0000_0200, 1);
        repeat (8) step(1, 1, 0, 32'h0, 1);
        // misaligned target and back-to-back redirects
        step(1, 1, 1, 32'h0000_0102, 1);
        repeat (6) step(1, 1, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 1, 32'h0000_0300, 1);
        step(1, 1, 1, 32'h0000_0403, 1);
        repeat (8) step(1, 1, 0, 32'h0, 1);
        // PC wrap
        step(1, 1, 1, 32'hffff_fff8, 1);
        repeat (8) step(1, 1, 0, 32'h0, 1);
        random_steps(600);
        // asynchronous reset mid-stream
        repeat (3) step(1, 1, 0, 32'h0, 0);
        #2 rst_ni = 0;
        #1 check_reset_outputs();
        model_reset();
        imem_gnt_i = 0; imem_rvalid_i = 0; redirect_i = 0; instr_ready_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        step(0, 1, 1, 32'h0000_0500, 1);
        repeat (4) step(1, 1, 0, 32'h0, 1);
        random_steps(400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
